led_display_mode_sequencer: RTL and testbench
=============================================

// Module: led_display_mode_sequencer
// PURPOSE
//  Drives mode_in of the LED pattern generator. Steps through display modes automatically on a dwell timer or on user
//  next/prev/load requests. Every change is applied only at a frame boundary reported by the display driver. The
//  generator is held at mode 0 (OFF) for BLANK_FRAMES frames before the new mode is applied, so a half-drawn mix is never shown.
// PARAMETERS
//  SYS_CLK_FREQ  100_000_000  system clock in Hz
//  SIMULATION    0            1: ms tick every 100 cycles; 0: every SYS_CLK_FREQ/1000 cycles
//  NUM_MODES     9            number of valid modes 0..NUM_MODES-1 (2..16); mode 0 = OFF
//  DWELL_MS      2000         auto-advance period in ms ticks (>=1)
//  BLANK_FRAMES  1            frames forced to OFF between modes (0..15)
// PORTS
//  clk_in           in   1  system clock
//  reset_in         in   1  asynchronous reset, active-high
//  enable_in        in   1  level; 0 drives display to OFF
//  auto_en_in       in   1  level; 1 enables dwell-timer auto-advance
//  next_in          in   1  one-cycle pulse; step to next mode
//  prev_in          in   1  one-cycle pulse; step to previous mode
//  load_in          in   1  one-cycle pulse; jump to load_mode_in
//  load_mode_in     in   4  mode for load_in
//  frame_done_in    in   1  one-cycle pulse from driver at end of each frame
//  mode_out         out  4  to pattern generator mode_in
//  busy_out         out  1  1 while a change is pending or blanking
//  mode_changed_out out  1  one-cycle pulse when a new non-zero mode is applied
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, mode_out=0, busy_out=0, mode_changed_out=0, target=0, cur=0, all counters 0.
//  Mode ring for stepping: 1..NUM_MODES-1. next: cur+1, wraps NUM_MODES-1 -> 1. prev: cur-1, wraps 1 -> NUM_MODES-1.
//    While busy, next/prev step from target instead of cur.
//  Event priority (same cycle): enable_in low > load_in > next_in > prev_in > dwell expiry. Lower events are dropped.
//  load_in with load_mode_in==0 or >=NUM_MODES is ignored.
//  ms tick: prescaler is free-running in all states. dwell_cnt counts ticks only in RUN with auto_en_in=1, else cleared.
//    Expiry = tick while dwell_cnt==DWELL_MS-1. dwell_cnt clears on expiry and on entry to RUN.
//  States:
//   IDLE: mode_out=0. enable_in=1 -> target=1, go PENDING.
//   RUN: mode_out=cur.
//     Event with new target != cur -> latch target, go PENDING.
//     Event with target==cur -> stay in RUN, clear dwell_cnt.
//     enable_in=0 -> target=0, go PENDING.
//   PENDING: mode_out=cur. New events overwrite target. Dwell expiry is ignored.
//     On frame_done_in:
//       target==0 -> mode_out<=0, go IDLE.
//       BLANK_FRAMES==0 -> cur<=target, mode_out<=target, pulse mode_changed_out, go RUN.
//       otherwise -> mode_out<=0, blank_cnt<=0, go BLANK.
//   BLANK: mode_out=0. New events overwrite target. blank_cnt increments on each frame_done_in.
//     On frame_done_in with blank_cnt==BLANK_FRAMES-1:
//       target==0 -> go IDLE.
//       otherwise -> cur<=target, mode_out<=target, pulse mode_changed_out, go RUN.
//  busy_out = 1 in PENDING/BLANK, registered with state.
//  Latency: mode_out updates on the clock edge that samples frame_done_in.
//  frame_done_in coincident with a new event: the frame completion is processed first, then the event is evaluated in
//    the next state on the following cycle. If that event changes target while in PENDING, the new target applies.
//  frame_done_in in IDLE or RUN is ignored.
// TESTING
//  Test parameters: SIMULATION=1, NUM_MODES=9, DWELL_MS=4, BLANK_FRAMES=1, frame_done_in every 50 cycles.
//  1. Release reset, enable_in=1 -> busy_out=1. Next frame_done -> mode_out=0 (BLANK). Following frame_done ->
//     mode_out=1, mode_changed_out pulse, busy_out=0.
//  2. auto_en_in=1 in mode 8, wait 400 cycles -> expiry. mode_out passes 8 -> 0 -> 1 on two frame_done pulses (wrap skips 0).
//  3. In mode 1: prev_in -> target 8. Then next_in twice before frame_done -> final mode_out=2 (steps from target).
//  4. load_in with load_mode_in=12 -> ignored, busy_out stays 0.
//     load_in and next_in in the same cycle with load_mode_in=5 -> mode 5 applied.
//  5. enable_in=0 in mode 3 -> mode_out=0 and state IDLE on the next frame_done, no mode_changed_out pulse.
//  6. Assert reset_in mid-BLANK, asynchronous to clk_in -> mode_out=0 and busy_out=0 immediately, without waiting for a
//     clock edge. After release, behaviour matches scenario 1.

Source files
------------

// File: rtl/led_display_mode_sequencer_if.sv
`default_nettype none
// led_display_mode_sequencer_if: request/status bundle between a display controller and the mode sequencer.
// Rev 1.0 - initial release.

interface led_display_mode_sequencer_if;
  logic       enable_in;
  logic       auto_en_in;
  logic       next_in;
  logic       prev_in;
  logic       load_in;
  logic [3:0] load_mode_in;
  logic       frame_done_in;
  logic [3:0] mode_out;
  logic       busy_out;
  logic       mode_changed_out;

  modport master (
    output enable_in, auto_en_in, next_in, prev_in, load_in, load_mode_in, frame_done_in,
    input  mode_out, busy_out, mode_changed_out
  );

  modport slave (
    input  enable_in, auto_en_in, next_in, prev_in, load_in, load_mode_in, frame_done_in,
    output mode_out, busy_out, mode_changed_out
  );
endinterface

`default_nettype wire

// File: rtl/led_display_mode_sequencer.sv
`default_nettype none
// led_display_mode_sequencer: frame-synchronous mode stepper with OFF blanking between modes.
// Rev 1.0 - initial release.

module led_display_mode_sequencer #(
  parameter int SYS_CLK_FREQ = 100_000_000,
  parameter int SIMULATION   = 0,
  parameter int NUM_MODES    = 9,
  parameter int DWELL_MS     = 2000,
  parameter int BLANK_FRAMES = 1
) (
  input  wire logic                  clk_in,
  input  wire logic                  reset_in,
  led_display_mode_sequencer_if.slave bus
);

  localparam int TICK_DIV = (SIMULATION != 0) ? 100 : (SYS_CLK_FREQ / 1000);
  localparam int PW       = $clog2(TICK_DIV + 1);
  localparam int DW       = $clog2(DWELL_MS + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_MS - 1);
  localparam logic [3:0]    LAST_MODE  = 4'(NUM_MODES - 1);
  localparam logic [3:0]    BLANK_LAST = 4'((BLANK_FRAMES == 0) ? 0 : BLANK_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PENDING = 2'd2,
    S_BLANK   = 2'd3
  } state_t;

  state_t          state;
  logic [3:0]      cur;
  logic [3:0]      target;
  logic [3:0]      mode_q;
  logic            busy_q;
  logic            changed_q;
  logic [PW-1:0]   presc;
  logic [DW-1:0]   dwell;
  logic [3:0]      blank_cnt;
  logic            defer_valid;
  logic            defer_load;
  logic            defer_next;
  logic            defer_prev;
  logic [3:0]      defer_mode;

  logic            tick;
  logic            expiry;
  logic            frame_hit;
  logic            ev_load;
  logic            ev_next;
  logic            ev_prev;
  logic [3:0]      ev_mode;
  logic            load_ok;
  logic [3:0]      base;
  logic [3:0]      base_next;
  logic [3:0]      base_prev;
  logic            req_valid;
  logic [3:0]      req_target;

  assign tick      = (presc == PRESC_LAST);
  assign expiry    = tick && (state == S_RUN) && bus.auto_en_in && (dwell == DWELL_LAST);
  assign frame_hit = bus.frame_done_in && ((state == S_PENDING) || (state == S_BLANK));

  // Requests that arrived with a frame completion are replayed one cycle later.
  always_comb begin
    ev_load = bus.load_in;
    ev_next = bus.next_in;
    ev_prev = bus.prev_in;
    ev_mode = bus.load_mode_in;
    if (defer_valid) begin
      ev_load = defer_load;
      ev_next = defer_next;
      ev_prev = defer_prev;
      ev_mode = defer_mode;
    end
  end

  assign load_ok   = ev_load && (ev_mode != 4'd0) && (ev_mode <= LAST_MODE);
  assign base      = (state == S_RUN) ? cur : target;
  assign base_next = (base >= LAST_MODE) ? 4'd1 : base + 4'd1;
  assign base_prev = (base <= 4'd1) ? LAST_MODE : base - 4'd1;

  always_comb begin
    req_valid  = 1'b1;
    req_target = 4'd0;
    if (!bus.enable_in) begin
      req_target = 4'd0;
    end else if (load_ok) begin
      req_target = ev_mode;
    end else if (ev_next) begin
      req_target = base_next;
    end else if (ev_prev) begin
      req_target = base_prev;
    end else if (expiry) begin
      req_target = base_next;
    end else begin
      req_valid = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state       <= S_IDLE;
      cur         <= 4'd0;
      target      <= 4'd0;
      mode_q      <= 4'd0;
      busy_q      <= 1'b0;
      changed_q   <= 1'b0;
      presc       <= '0;
      dwell       <= '0;
      blank_cnt   <= 4'd0;
      defer_valid <= 1'b0;
      defer_load  <= 1'b0;
      defer_next  <= 1'b0;
      defer_prev  <= 1'b0;
      defer_mode  <= 4'd0;
    end else begin
      changed_q <= 1'b0;
      presc     <= tick ? '0 : presc + 1'b1;

      if ((state == S_RUN) && bus.auto_en_in) begin
        if (expiry) begin
          dwell <= '0;
        end else if (tick) begin
          dwell <= dwell + 1'b1;
        end
      end else begin
        dwell <= '0;
      end

      defer_valid <= frame_hit && (bus.load_in || bus.next_in || bus.prev_in);
      defer_load  <= bus.load_in;
      defer_next  <= bus.next_in;
      defer_prev  <= bus.prev_in;
      defer_mode  <= bus.load_mode_in;

      case (state)
        S_IDLE: begin
          if (bus.enable_in) begin
            target <= 4'd1;
            busy_q <= 1'b1;
            state  <= S_PENDING;
          end
        end

        S_RUN: begin
          if (req_valid) begin
            if (req_target != cur) begin
              target <= req_target;
              busy_q <= 1'b1;
              state  <= S_PENDING;
            end else begin
              dwell <= '0;
            end
          end
        end

        S_PENDING: begin
          if (bus.frame_done_in) begin
            if (target == 4'd0) begin
              // Clearing cur keeps the next power-up from flashing the old mode.
              cur    <= 4'd0;
              mode_q <= 4'd0;
              busy_q <= 1'b0;
              state  <= S_IDLE;
            end else if (BLANK_FRAMES == 0) begin
              cur       <= target;
              mode_q    <= target;
              changed_q <= 1'b1;
              busy_q    <= 1'b0;
              state     <= S_RUN;
            end else begin
              mode_q    <= 4'd0;
              blank_cnt <= 4'd0;
              state     <= S_BLANK;
            end
          end else if (req_valid) begin
            target <= req_target;
          end
        end

        S_BLANK: begin
          if (bus.frame_done_in) begin
            if (blank_cnt == BLANK_LAST) begin
              busy_q <= 1'b0;
              if (target == 4'd0) begin
                cur   <= 4'd0;
                state <= S_IDLE;
              end else begin
                cur       <= target;
                mode_q    <= target;
                changed_q <= 1'b1;
                state     <= S_RUN;
              end
            end else begin
              blank_cnt <= blank_cnt + 4'd1;
            end
          end else if (req_valid) begin
            target <= req_target;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mode_out         = mode_q;
  assign bus.busy_out         = busy_q;
  assign bus.mode_changed_out = changed_q;

endmodule

`default_nettype wire

// File: tb/tb_led_display_mode_sequencer.sv
`default_nettype none
// tb_led_display_mode_sequencer: vector table, dwell/reset sequences and a randomized run against a reference model.
// Rev 1.0 - initial release.

module tb_led_display_mode_sequencer;
  localparam int NM    = 9;
  localparam int DWELL = 4;
  localparam int BF    = 1;
  localparam int TICK  = 100;

  localparam int PH_OFF   = 0;
  localparam int PH_SHOW  = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_BLANK = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  led_display_mode_sequencer_if bus ();

  led_display_mode_sequencer #(
    .SYS_CLK_FREQ(100_000_000),
    .SIMULATION  (1),
    .NUM_MODES   (NM),
    .DWELL_MS    (DWELL),
    .BLANK_FRAMES(BF)
  ) dut (
    .clk_in  (clk),
    .reset_in(rst),
    .bus     (bus)
  );

  typedef struct {
    bit ld;
    bit nx;
    bit pv;
    int lm;
  } req_t;

  typedef struct {
    int idle;
    bit en;
    bit au;
    bit nx;
    bit pv;
    bit ld;
    int lm;
    bit fd;
    int mode;
    int busy;
    int chg;
  } vec_t;

  // Reference model: phase of the display, the shown and wanted modes, and an absolute edge count.
  int   m_phase;
  int   m_shown;
  int   m_goal;
  int   m_blanks;
  int   m_dwell;
  int   m_edges;
  bit   m_pulse;
  req_t held[$];

  function automatic int ring_next(int m);
    return (m % (NM - 1)) + 1;
  endfunction

  function automatic int ring_prev(int m);
    if (m <= 1) return NM - 1;
    return m - 1;
  endfunction

  function automatic void model_reset();
    m_phase  = PH_OFF;
    m_shown  = 0;
    m_goal   = 0;
    m_blanks = 0;
    m_dwell  = 0;
    m_edges  = 0;
    m_pulse  = 1'b0;
    held.delete();
  endfunction

  function automatic int m_mode();
    return (m_phase == PH_SHOW || m_phase == PH_WAIT) ? m_shown : 0;
  endfunction

  function automatic void model_step();
    req_t live;
    req_t ev;
    bit   tick;
    bit   expiry;
    bit   frame;
    bit   has_req;
    int   base;
    int   req;
    live.ld = bus.load_in;
    live.nx = bus.next_in;
    live.pv = bus.prev_in;
    live.lm = int'(bus.load_mode_in);
    ev = live;
    if (held.size() > 0) ev = held.pop_front();
    tick = (m_edges % TICK) == (TICK - 1);
    m_edges++;
    m_pulse = 1'b0;
    frame  = bus.frame_done_in && (m_phase == PH_WAIT || m_phase == PH_BLANK);
    expiry = (m_phase == PH_SHOW) && bus.auto_en_in && tick && (m_dwell == DWELL - 1);
    if (m_phase == PH_SHOW && bus.auto_en_in) m_dwell = expiry ? 0 : m_dwell + int'(tick);
    else m_dwell = 0;
    if (frame) begin
      if (live.ld || live.nx || live.pv) held.push_back(live);
      if (m_phase == PH_WAIT && m_goal != 0 && BF > 0) begin
        m_phase  = PH_BLANK;
        m_blanks = 0;
      end else if (m_phase == PH_BLANK && m_blanks < BF - 1) begin
        m_blanks++;
      end else if (m_goal == 0) begin
        m_phase = PH_OFF;
        m_shown = 0;
      end else begin
        m_shown = m_goal;
        m_phase = PH_SHOW;
        m_pulse = 1'b1;
      end
      return;
    end
    base    = (m_phase == PH_SHOW) ? m_shown : m_goal;
    has_req = 1'b1;
    if (!bus.enable_in)                            req = 0;
    else if (ev.ld && ev.lm >= 1 && ev.lm < NM)    req = ev.lm;
    else if (ev.nx)                                req = ring_next(base);
    else if (ev.pv)                                req = ring_prev(base);
    else if (expiry)                               req = ring_next(base);
    else begin
      has_req = 1'b0;
      req     = 0;
    end
    case (m_phase)
      PH_OFF: begin
        if (bus.enable_in) begin
          m_goal  = 1;
          m_phase = PH_WAIT;
        end
      end
      PH_SHOW: begin
        if (has_req) begin
          if (req != m_shown) begin
            m_goal  = req;
            m_phase = PH_WAIT;
          end else begin
            m_dwell = 0;
          end
        end
      end
      default: begin
        if (has_req) m_goal = req;
      end
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit use_model);
    @(posedge clk);
    model_step();
    #1;
    bus.next_in       = 1'b0;
    bus.prev_in       = 1'b0;
    bus.load_in       = 1'b0;
    bus.frame_done_in = 1'b0;
    if (use_model) begin
      check("model_mode", int'(bus.mode_out), m_mode());
      check("model_busy", int'(bus.busy_out), int'(m_phase >= PH_WAIT));
      check("model_changed", int'(bus.mode_changed_out), int'(m_pulse));
    end
  endtask

  task automatic frame();
    bus.frame_done_in = 1'b1;
    step(1'b1);
  endtask

  task automatic pulse_load(input int m);
    bus.load_in      = 1'b1;
    bus.load_mode_in = 4'(m);
    step(1'b1);
  endtask

  vec_t tbl[22];

  initial begin
    #500_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r;
    int r2;
    bit quiet;

    //         idle en au nx pv ld lm  fd  mode busy chg
    tbl[0]  = '{2, 1, 0, 0, 0, 0, 0,  0,  0,   1,   0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 0,  1,  0,   1,   0};
    tbl[2]  = '{3, 1, 0, 0, 0, 0, 0,  1,  1,   0,   1};
    tbl[3]  = '{1, 1, 0, 0, 0, 0, 0,  0,  1,   0,   0};
    tbl[4]  = '{0, 1, 0, 0, 0, 1, 12, 0,  1,   0,   0};
    tbl[5]  = '{1, 1, 0, 1, 0, 1, 5,  0,  1,   1,   0};
    tbl[6]  = '{2, 1, 0, 0, 0, 0, 0,  1,  0,   1,   0};
    tbl[7]  = '{2, 1, 0, 0, 0, 0, 0,  1,  5,   0,   1};
    tbl[8]  = '{1, 1, 0, 0, 0, 1, 1,  0,  5,   1,   0};
    tbl[9]  = '{0, 1, 0, 0, 0, 0, 0,  1,  0,   1,   0};
    tbl[10] = '{0, 1, 0, 0, 0, 0, 0,  1,  1,   0,   1};
    tbl[11] = '{1, 1, 0, 0, 1, 0, 0,  0,  1,   1,   0};
    tbl[12] = '{0, 1, 0, 1, 0, 0, 0,  0,  1,   1,   0};
    tbl[13] = '{0, 1, 0, 1, 0, 0, 0,  0,  1,   1,   0};
    tbl[14] = '{0, 1, 0, 0, 0, 0, 0,  1,  0,   1,   0};
    tbl[15] = '{0, 1, 0, 0, 0, 0, 0,  1,  2,   0,   1};
    tbl[16] = '{1, 1, 0, 0, 0, 1, 3,  0,  2,   1,   0};
    tbl[17] = '{0, 1, 0, 0, 0, 0, 0,  1,  0,   1,   0};
    tbl[18] = '{0, 1, 0, 0, 0, 0, 0,  1,  3,   0,   1};
    tbl[19] = '{1, 0, 0, 0, 0, 0, 0,  0,  3,   1,   0};
    tbl[20] = '{0, 0, 0, 0, 0, 0, 0,  1,  0,   0,   0};
    tbl[21] = '{3, 0, 0, 0, 0, 0, 0,  0,  0,   0,   0};

    bus.enable_in     = 1'b0;
    bus.auto_en_in    = 1'b0;
    bus.next_in       = 1'b0;
    bus.prev_in       = 1'b0;
    bus.load_in       = 1'b0;
    bus.load_mode_in  = 4'd0;
    bus.frame_done_in = 1'b0;
    model_reset();

    #1;
    check("reset_mode", int'(bus.mode_out), 0);
    check("reset_busy", int'(bus.busy_out), 0);
    check("reset_changed", int'(bus.mode_changed_out), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1);

    // Directed vectors: power-up, load/priority, stepping from target, power-down.
    for (int i = 0; i < 22; i++) begin
      bus.enable_in  = tbl[i].en;
      bus.auto_en_in = tbl[i].au;
      repeat (tbl[i].idle) step(1'b1);
      bus.next_in       = tbl[i].nx;
      bus.prev_in       = tbl[i].pv;
      bus.load_in       = tbl[i].ld;
      bus.load_mode_in  = 4'(tbl[i].lm);
      bus.frame_done_in = tbl[i].fd;
      step(1'b0);
      check($sformatf("vec%0d_mode", i), int'(bus.mode_out), tbl[i].mode);
      check($sformatf("vec%0d_busy", i), int'(bus.busy_out), tbl[i].busy);
      check($sformatf("vec%0d_changed", i), int'(bus.mode_changed_out), tbl[i].chg);
    end

    // Dwell expiry from mode 8 wraps to mode 1 through one blank frame.
    bus.enable_in = 1'b1;
    step(1'b1);
    frame();
    frame();
    pulse_load(8);
    frame();
    frame();
    check("dwell_start_mode", int'(bus.mode_out), 8);
    bus.auto_en_in = 1'b1;
    n = 0;
    while (!bus.busy_out && n < 450) begin
      step(1'b1);
      n++;
    end
    check("dwell_window", int'(n >= 301 && n <= 400), 1);
    check("dwell_hold_mode", int'(bus.mode_out), 8);
    frame();
    check("dwell_blank_mode", int'(bus.mode_out), 0);
    frame();
    check("dwell_wrap_mode", int'(bus.mode_out), 1);
    check("dwell_wrap_changed", int'(bus.mode_changed_out), 1);
    bus.auto_en_in = 1'b0;

    // Asynchronous reset while blanking, then a clean power-up.
    pulse_load(4);
    frame();
    check("preblank_busy", int'(bus.busy_out), 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_mode", int'(bus.mode_out), 0);
    check("async_rst_busy", int'(bus.busy_out), 0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1);
    check("rerun_busy", int'(bus.busy_out), 1);
    frame();
    check("rerun_blank_mode", int'(bus.mode_out), 0);
    frame();
    check("rerun_mode", int'(bus.mode_out), 1);
    check("rerun_changed", int'(bus.mode_changed_out), 1);
    check("rerun_idle_busy", int'(bus.busy_out), 0);

    // Randomized traffic: frames every 50 cycles, alternating busy and quiet stretches.
    for (int k = 0; k < 3000; k++) begin
      quiet = ((k / 500) % 2) == 1;
      if (k % 50 == 20) begin
        bus.enable_in  = ($urandom_range(0, 9) != 0);
        bus.auto_en_in = quiet ? 1'b1 : 1'($urandom_range(0, 1));
      end
      bus.frame_done_in = (k % 50 == 49);
      if (k % 50 != 0) begin
        r = int'($urandom_range(0, quiet ? 999 : 15));
        case (r)
          0: bus.next_in = 1'b1;
          1: bus.prev_in = 1'b1;
          2: begin
            bus.load_in      = 1'b1;
            bus.load_mode_in = 4'($urandom_range(1, NM - 1));
          end
          3: begin
            r2 = int'($urandom_range(0, 7));
            bus.load_in      = 1'b1;
            bus.load_mode_in = 4'((r2 == 0) ? 0 : 8 + r2);
          end
          4: begin
            bus.load_in      = 1'b1;
            bus.next_in      = 1'b1;
            bus.load_mode_in = 4'($urandom_range(1, NM - 1));
          end
          5: begin
            bus.next_in = 1'b1;
            bus.prev_in = 1'b1;
          end
          default: ;
        endcase
      end
      step(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
